pipelined_cla_adder: RTL
========================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised N-bit carry-lookahead adder, split into STAGES pipeline slices.
//  Each slice is built from GROUP-bit lookahead cells plus a group-level lookahead.
//  The carry is registered between slices; operand slices are skewed to match.
//  Valid/ready handshake on both sides; drop-in arithmetic unit for datapath blocks.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits; must be a multiple of GROUP*STAGES
//  GROUP   4   bits per lookahead cell (generate/propagate group size)
//  STAGES  2   pipeline register stages = slices; latency in cycles (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      a/b/cin valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry into bit 0
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (only when CLA_OVF_EN is defined)
// BEHAVIOUR
//  - Slice k (k=0..STAGES-1) covers bits [(k+1)*W/S-1 : k*W/S].
//    Slice k is computed in pipeline stage k from the registered carry of slice k-1.
//  - Inside a slice: p=a^b, g=a&b per bit; group G/P per GROUP bits.
//    Carries are full lookahead (no ripple between bits inside a group).
//  - advance = !out_valid | out_ready; in_ready = advance (combinational).
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - On advance, every stage register loads from the previous stage.
//    Each stage carries a valid bit; bubbles propagate and are not collapsed.
//  - On !advance, all stage registers hold, including partial sums, skewed operands and carries.
//  - Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
//  - Throughput: 1 result/cycle while out_ready=1.
//  - Order preserved; no result is dropped or duplicated under any out_ready pattern.
//  - Reset (async, any time): all stage valid bits=0, out_valid=0, sum=0, cout=0, ovf=0.
//    In-flight operations are discarded; in_ready=1 immediately after reset.
//  - Width rules: sum truncated to WIDTH bits; cout is the true carry.
//    With all-ones operands plus cin=1, cout=1 and no other flag side effects.
//  - Outputs are driven from registers only; no combinational path from a/b to sum.
//  - Invalid parameter combinations (WIDTH % (GROUP*STAGES) != 0) fail elaboration via a generate-time error.
// CONFIGURATION
//  CLA_OVF_EN defined:
//    - ovf port exists; ovf = carry into MSB ^ cout, registered alongside sum.
//  CLA_OVF_EN undefined:
//    - ovf port and its logic are absent; all other behaviour is identical.
// TESTING (WIDTH=16, GROUP=4, STAGES=2 unless noted)
//  1 a=16'h1234 b=16'h4321 cin=0, out_ready=1 -> 2 cycles later sum=16'h5555 cout=0
//  2 a=16'hFFFF b=16'h0000 cin=1 -> sum=16'h0000 cout=1 (carry crosses every group and slice)
//  3 back-to-back inputs i=0..7 a=i b=i, out_ready=1 -> sums 0,2,..,14 on consecutive cycles
//  4 out_ready=0 for 3 cycles mid-stream -> in_ready=0, sum held stable; resume gives no loss/dup
//  5 rst pulsed with 2 ops in flight -> out_valid=0 same cycle; no stale result after release
//  6 CLA_OVF_EN: a=16'h7FFF b=16'h0001 -> sum=16'h8000 ovf=1 cout=0
//    also a=16'h8000 b=16'h8000 -> sum=0 ovf=1 cout=1
//    also repeat scenario 3 with STAGES=4, GROUP=2: latency=4

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder with valid/ready handshake
//
// Purpose:
//   WIDTH-bit adder split into STAGES slices of WIDTH/STAGES bits. Slice k is
//   summed in pipeline stage k using GROUP-bit lookahead cells and a
//   group-level lookahead. The carry out of each slice is registered. The
//   operand bits that later slices still need travel with it, so each result
//   leaves after exactly STAGES cycles.
//
// Optional feature:
//   CLA_OVF_EN - when defined, adds the ovf output: a registered signed overflow.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   a/b/cin valid this cycle
//   in_ready   block accepts operands this cycle
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  sum/cout valid
//   out_ready  downstream accepts result
//   sum        (a+b+cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (CLA_OVF_EN only)

module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW = WIDTH / STAGES;   // bits per slice
    localparam int NG = SW / GROUP;       // lookahead cells per slice

    generate
        if (STAGES < 1 || GROUP < 1 || (WIDTH % (GROUP * STAGES)) != 0) begin : g_bad_params
            $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP*STAGES");
        end
    endgenerate

    // One slice of full carry lookahead. The return value is {carry_out, sum}.
    // Every carry is written as a sum of products of g/p terms, both inside a
    // cell and across cells. No carry is computed from a neighbouring carry.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW-1:0] c;
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic [NG:0]   gc;
        logic          t;
        p = x ^ y;
        g = x & y;
        // Cell generate/propagate.
        for (int m = 0; m < NG; m++) begin
            gp[m] = 1'b1;
            gg[m] = 1'b0;
            for (int i = 0; i < GROUP; i++) begin
                gp[m] = gp[m] & p[m*GROUP+i];
                t = g[m*GROUP+i];
                for (int j = i + 1; j < GROUP; j++) begin
                    t = t & p[m*GROUP+j];
                end
                gg[m] = gg[m] | t;
            end
        end
        // Carry into each cell (gc[NG] is the slice carry out).
        for (int m = 0; m <= NG; m++) begin
            t = ci;
            for (int n = 0; n < m; n++) begin
                t = t & gp[n];
            end
            gc[m] = t;
            for (int l = 0; l < m; l++) begin
                t = gg[l];
                for (int n = l + 1; n < m; n++) begin
                    t = t & gp[n];
                end
                gc[m] = gc[m] | t;
            end
        end
        // Carry into each bit, expanded from its cell carry-in.
        for (int m = 0; m < NG; m++) begin
            for (int i = 0; i < GROUP; i++) begin
                t = gc[m];
                for (int j = 0; j < i; j++) begin
                    t = t & p[m*GROUP+j];
                end
                c[m*GROUP+i] = t;
                for (int j = 0; j < i; j++) begin
                    t = g[m*GROUP+j];
                    for (int q = j + 1; q < i; q++) begin
                        t = t & p[m*GROUP+q];
                    end
                    c[m*GROUP+i] = c[m*GROUP+i] | t;
                end
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    // The whole pipe moves as one unit. A bubble occupies its slot like a
    // result does, so order and the fixed latency are preserved.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            // RW counts the operand bits still to be summed on entry to stage k.
            localparam int RW = WIDTH - k * SW;

            logic [RW-1:0]       src_a;
            logic [RW-1:0]       src_b;
            logic                src_c;
            logic                src_v;
            logic [SW:0]         res;
            logic [(k+1)*SW-1:0] nxt_s;
            logic [(k+1)*SW-1:0] rs;
            logic                rc;
            logic                rv;

            if (k == 0) begin : g_first
                assign src_a = a;
                assign src_b = b;
                assign src_c = cin;
                assign src_v = in_valid;
                assign nxt_s = res[SW-1:0];
            end else begin : g_next
                assign src_a = g_stage[k-1].g_ops.ra;
                assign src_b = g_stage[k-1].g_ops.rb;
                assign src_c = g_stage[k-1].rc;
                assign src_v = g_stage[k-1].rv;
                assign nxt_s = {res[SW-1:0], g_stage[k-1].rs};
            end

            assign res = cla_slice(src_a[SW-1:0], src_b[SW-1:0], src_c);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rv <= 1'b0;
                    rc <= 1'b0;
                    rs <= '0;
                end else if (advance) begin
                    rv <= src_v;
                    rc <= res[SW];
                    rs <= nxt_s;
                end
            end

            // Skewed operands: only the bits of the slices not yet summed.
            if (k < STAGES - 1) begin : g_ops
                logic [RW-SW-1:0] ra;
                logic [RW-SW-1:0] rb;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ra <= '0;
                        rb <= '0;
                    end else if (advance) begin
                        ra <= src_a[RW-1:SW];
                        rb <= src_b[RW-1:SW];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].rv;
    assign sum       = g_stage[STAGES-1].rs;
    assign cout      = g_stage[STAGES-1].rc;

`ifdef CLA_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
    logic msb_carry;
    assign msb_carry = g_stage[STAGES-1].res[SW-1] ^ g_stage[STAGES-1].src_a[SW-1]
                     ^ g_stage[STAGES-1].src_b[SW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= msb_carry ^ g_stage[STAGES-1].res[SW];
        end
    end
`endif

endmodule
